// File: rtl/uart_pkg.sv
// Shared UART definitions: transmitter FSM states and serial line levels.
// Also intended for reuse by the receive side.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } uart_tx_state_e;

  localparam logic UART_IDLE_LEVEL  = 1'b1;
  localparam logic UART_START_LEVEL = 1'b0;

endpackage : uart_pkg

// File: rtl/uart_baud_gen.sv
// Bit-period generator: counts 0..CLKS_PER_BIT-1 and flags the last cycle
// of every bit period. A restart pulse realigns the period to the next cycle.
module uart_baud_gen #(
  parameter int unsigned CLKS_PER_BIT = 16
) (
  input  logic clk,
  input  logic reset_n,
  input  logic restart,
  output logic bit_tick,
  output logic bit_tick_pre
);

  localparam int unsigned CNT_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_PRE  = CNT_W'(CLKS_PER_BIT - 2);

  logic [CNT_W-1:0] cnt_q;

  // Free-running bit-period counter, cleared on restart and at wrap
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else if (restart || (cnt_q == CNT_LAST)) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  // Last cycle of the bit period, and the cycle just before it
  assign bit_tick     = (cnt_q == CNT_LAST);
  assign bit_tick_pre = (cnt_q == CNT_PRE);

endmodule : uart_baud_gen

// File: rtl/uart_tx.sv
// UART transmitter fed from the transmit FIFO. Pops a byte whenever idle (or
// finishing the final stop bit) and enabled, then serializes start, LSB-first
// data, optional parity and stop bits onto tx.
// Optional feature macro: UART_TX_PARITY_EN inserts a parity bit after the data.
module uart_tx
  import uart_pkg::*;
#(
  parameter int unsigned DATA_SIZE    = 8,
  parameter int unsigned CLKS_PER_BIT = 16,
  parameter int unsigned STOP_BITS    = 1
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 tx_en,
  input  logic                 parity_odd,
  input  logic [DATA_SIZE-1:0] fifo_data,
  input  logic                 fifo_empty,
  output logic                 fifo_read,
  output logic                 tx,
  output logic                 busy,
  output logic                 tx_done
);

  localparam int unsigned BIT_CNT_W = $clog2(DATA_SIZE) + 1;
  localparam logic [BIT_CNT_W-1:0] DATA_LAST = BIT_CNT_W'(DATA_SIZE - 1);
  localparam logic [BIT_CNT_W-1:0] STOP_LAST = BIT_CNT_W'(STOP_BITS - 1);

  uart_tx_state_e         state_q, state_d;
  logic [DATA_SIZE-1:0]   shreg_q, shreg_d;
  logic [BIT_CNT_W-1:0]   bit_cnt_q, bit_cnt_d;
  logic                   tx_d;
  logic                   busy_d;
  logic                   tx_done_d;
  logic                   bit_tick;
  logic                   bit_tick_pre;
  logic                   stop_final_c;
  logic                   last_stop_c;
  logic                   load_c;

`ifdef UART_TX_PARITY_EN
  logic                   parity_q, parity_d;
`else
  logic                   unused_parity_odd;
  assign unused_parity_odd = parity_odd;
`endif

  // Bit timing, realigned to the pop edge of every frame
  uart_baud_gen #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_baud_gen (
    .clk          (clk),
    .reset_n      (reset_n),
    .restart      (load_c),
    .bit_tick     (bit_tick),
    .bit_tick_pre (bit_tick_pre)
  );

  // Frame boundary and FIFO pop decision
  assign stop_final_c = (bit_cnt_q == STOP_LAST);
  assign last_stop_c  = (state_q == STOP) && bit_tick && stop_final_c;
  assign load_c       = tx_en && !fifo_empty && ((state_q == IDLE) || last_stop_c);
  assign fifo_read    = load_c;

  // State, datapath and output registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      shreg_q   <= '0;
      bit_cnt_q <= '0;
      tx        <= UART_IDLE_LEVEL;
      busy      <= 1'b0;
      tx_done   <= 1'b0;
`ifdef UART_TX_PARITY_EN
      parity_q  <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      shreg_q   <= shreg_d;
      bit_cnt_q <= bit_cnt_d;
      tx        <= tx_d;
      busy      <= busy_d;
      tx_done   <= tx_done_d;
`ifdef UART_TX_PARITY_EN
      parity_q  <= parity_d;
`endif
    end
  end

  // Next-state, datapath and registered-output next values
  always_comb begin
    state_d   = state_q;
    shreg_d   = shreg_q;
    bit_cnt_d = bit_cnt_q;
    tx_done_d = 1'b0;
`ifdef UART_TX_PARITY_EN
    parity_d  = parity_q;
`endif

    case (state_q)
      IDLE: begin
        state_d = IDLE;
      end
      START: begin
        if (bit_tick) begin
          state_d   = DATA;
          bit_cnt_d = '0;
        end
      end
      DATA: begin
        if (bit_tick) begin
          if (bit_cnt_q == DATA_LAST) begin
`ifdef UART_TX_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
            bit_cnt_d = '0;
          end else begin
            bit_cnt_d = bit_cnt_q + BIT_CNT_W'(1);
            shreg_d   = shreg_q >> 1;
          end
        end
      end
      PARITY: begin
        if (bit_tick) begin
          state_d   = STOP;
          bit_cnt_d = '0;
        end
      end
      STOP: begin
        // Pulse is registered, so it is armed one cycle before the final tick
        if (stop_final_c && bit_tick_pre) begin
          tx_done_d = 1'b1;
        end
        if (bit_tick) begin
          if (stop_final_c) begin
            state_d   = IDLE;
            bit_cnt_d = '0;
          end else begin
            bit_cnt_d = bit_cnt_q + BIT_CNT_W'(1);
          end
        end
      end
      default: begin
        state_d   = IDLE;
        bit_cnt_d = '0;
      end
    endcase

    // A pop overrides everything: capture the word and start a new frame
    if (load_c) begin
      state_d   = START;
      shreg_d   = fifo_data;
      bit_cnt_d = '0;
`ifdef UART_TX_PARITY_EN
      parity_d  = (^fifo_data) ^ parity_odd;
`endif
    end

    // Line level follows the state being entered, keeping tx glitch-free
    case (state_d)
      START:   tx_d = UART_START_LEVEL;
      DATA:    tx_d = shreg_d[0];
`ifdef UART_TX_PARITY_EN
      PARITY:  tx_d = parity_d;
`endif
      default: tx_d = UART_IDLE_LEVEL;
    endcase

    busy_d = (state_d != IDLE);
  end

endmodule : uart_tx
